picomem_wb_bridge: RTL and testbench

- PicoMem slave to Wishbone B4 classic master bridge; occupies the Wishbone slot (0xC000_0000 window) of the top-level PicoMem 1:4 mux.
- Converts each PicoMem transaction into exactly one single-beat Wishbone cycle and returns the registered response as a one-cycle mem_s_ready pulse.
- Gives the system an off-core Wishbone peripheral bus, replacing the constant-ready stub.

---
 rtl/picomem_wb_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_picomem_wb_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picomem_wb_bridge.sv
// ---------------------------------------------------------------------------
// picomem_wb_bridge
//
// Purpose:
//   PicoMem slave to Wishbone B4 classic master bridge. Each accepted PicoMem
//   request becomes exactly one single-beat Wishbone cycle. The response is
//   registered and returned to the PicoMem master as a one-cycle mem_s_ready
//   pulse. No address decode is done here; the upstream mux has already
//   selected this slot.
//
// Handshake summary (both sides):
//   PicoMem: a request is taken when mem_s_valid=1 at a clock edge while the
//   bridge is IDLE. The response is the single cycle in which mem_s_ready=1;
//   mem_s_rdata is valid in that cycle and held until the next response.
//   Wishbone: cyc/stb are high for the whole BUS state with adr/dat/sel/we
//   held stable; the cycle ends at the first edge where wb_ack_i or wb_err_i
//   is high (err wins when both are high).
//
// Optional feature:
//   Define PICOMEM_WB_TIMEOUT_EN to enable a BUS-state watchdog that ends an
//   unanswered Wishbone cycle after TIMEOUT_CYCLES cycles, exactly as if the
//   slave had signalled err. Without it, BUS waits indefinitely.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   mem_s_valid/ready            PicoMem request valid / response pulse
//   mem_s_addr/wdata/wstrb       PicoMem byte address, write data, strobes
//   mem_s_rdata                  PicoMem read data (valid while ready=1)
//   wb_cyc_o/stb_o/we_o          Wishbone cycle, strobe, write enable
//   wb_adr_o/dat_o/sel_o         Wishbone word address, write data, selects
//   wb_dat_i/ack_i/err_i         Wishbone read data, acknowledge, error
//   err_clr                      clear pulse for the sticky bus_err flag
//   bus_err                      sticky error flag
// ---------------------------------------------------------------------------
module picomem_wb_bridge #(
    parameter int          ADDR_W         = 24,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              mem_s_valid,
    output logic              mem_s_ready,
    input  logic [31:0]       mem_s_addr,
    input  logic [31:0]       mem_s_wdata,
    input  logic [3:0]        mem_s_wstrb,
    output logic [31:0]       mem_s_rdata,

    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,

    input  logic              err_clr,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  adr_q,   adr_d;
    logic [31:0]        dat_q,   dat_d;
    logic [3:0]         sel_q,   sel_d;
    logic               we_q,    we_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_err_q, bus_err_d;

    // Error termination this cycle (slave err or watchdog expiry).
    logic               term_err;
    // Watchdog expiry; tied low when the feature is compiled out.
    logic               timeout_hit;

    // Only the word-address bits inside the window reach the Wishbone side.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_s_addr[31:ADDR_W+2], mem_s_addr[1:0]};

`ifdef PICOMEM_WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counter is zero on entry to BUS (it is held at zero outside BUS) and
    // counts every BUS cycle, so the watchdog fires in BUS cycle number
    // TIMEOUT_CYCLES when nothing has answered.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_BUS) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_BUS) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Watchdog compiled out: BUS waits for ack/err indefinitely.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        term_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_s_valid) begin
                    adr_d   = mem_s_addr[ADDR_W+1:2];
                    dat_d   = mem_s_wdata;
                    we_d    = |mem_s_wstrb;
                    sel_d   = (|mem_s_wstrb) ? mem_s_wstrb : 4'b1111;
                    state_d = ST_BUS;
                end
            end

            ST_BUS: begin
                // Priority: slave err, then slave ack, then watchdog.
                if (wb_err_i) begin
                    term_err = 1'b1;
                end else if (wb_ack_i) begin
                    rdata_d = we_q ? 32'h0 : wb_dat_i;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    term_err = 1'b1;
                end

                if (term_err) begin
                    rdata_d = we_q ? 32'h0 : ERR_RDATA;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                // Valid is not sampled here; the master presents its next
                // request in the IDLE cycle that follows the ready pulse.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error: a set in the same cycle as a clear wins.
    always_comb begin
        bus_err_d = bus_err_q;
        if (term_err) begin
            bus_err_d = 1'b1;
        end else if (err_clr) begin
            bus_err_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded from flops, so reset drops them immediately.
    // -----------------------------------------------------------------------
    assign wb_cyc_o    = (state_q == ST_BUS);
    assign wb_stb_o    = (state_q == ST_BUS);
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign mem_s_ready = (state_q == ST_RESP);
    assign mem_s_rdata = rdata_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_picomem_wb_bridge
//
// Self-checking bench for picomem_wb_bridge. A small Wishbone slave model
// answers with a programmable number of wait states, ack and/or err, and a
// programmable read word. Directed vectors live in a table; multi-cycle
// corner cases (err_clr races, back-to-back, reset mid-cycle, watchdog) are
// written out by hand. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_picomem_wb_bridge;

    localparam int ADDR_W = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              mem_s_valid = 1'b0;
    logic              mem_s_ready;
    logic [31:0]       mem_s_addr  = '0;
    logic [31:0]       mem_s_wdata = '0;
    logic [3:0]        mem_s_wstrb = '0;
    logic [31:0]       mem_s_rdata;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              err_clr = 1'b0;
    logic              bus_err;

    picomem_wb_bridge #(
        .ADDR_W         (ADDR_W),
        .ERR_RDATA      (32'hDEAD_BEEF),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_s_valid (mem_s_valid),
        .mem_s_ready (mem_s_ready),
        .mem_s_addr  (mem_s_addr),
        .mem_s_wdata (mem_s_wdata),
        .mem_s_wstrb (mem_s_wstrb),
        .mem_s_rdata (mem_s_rdata),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .err_clr     (err_clr),
        .bus_err     (bus_err)
    );

    // ---------------- Wishbone slave model ----------------
    int          slv_ws     = 0;
    logic        slv_ack_en = 1'b1;
    logic        slv_err_en = 1'b0;
    logic [31:0] slv_rdata  = '0;
    int          ws_cnt     = 0;

    // ws_cnt = number of completed strobe cycles in the current Wishbone cycle.
    always @(posedge clk) begin
        if (!wb_stb_o) ws_cnt <= 0;
        else           ws_cnt <= ws_cnt + 1;
    end

    assign wb_ack_i = wb_stb_o && slv_ack_en && (ws_cnt == slv_ws);
    assign wb_err_i = wb_stb_o && slv_err_en && (ws_cnt == slv_ws);
    assign wb_dat_i = slv_rdata;

    // ---------------- event counters ----------------
    int   stb_rises = 0;
    int   ready_cnt = 0;
    logic stb_d     = 1'b0;
    always @(posedge clk) begin
        stb_d <= wb_stb_o;
        if (wb_stb_o && !stb_d) stb_rises <= stb_rises + 1;
        if (mem_s_ready)        ready_cnt <= ready_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
        int                ws;
        bit                ack;
        bit                err;
        bit                drop_valid;
        bit                clr_before;
        logic [31:0]       rdata_in;
        logic [ADDR_W-1:0] exp_adr;
        logic [3:0]        exp_sel;
        bit                exp_we;
        logic [31:0]       exp_rdata;
        int                exp_lat;
        bit                exp_bus_err;
    } vec_t;

    vec_t vecs[5];

    // Called just after a falling edge with the DUT idle. Issues one request,
    // checks the Wishbone side, waits (bounded) for ready, checks the
    // response, and returns in the IDLE cycle after the ready pulse.
    task automatic do_req(input vec_t v, input bit clr_in_bus, input string nm);
        int lat;
        bit stable_ok;
        bit done;
        mem_s_valid = 1'b1;
        mem_s_addr  = v.addr;
        mem_s_wdata = v.wdata;
        mem_s_wstrb = v.wstrb;
        slv_ws      = v.ws;
        slv_ack_en  = v.ack;
        slv_err_en  = v.err;
        slv_rdata   = v.rdata_in;
        err_clr     = v.clr_before;
        @(negedge clk);
        lat     = 1;
        err_clr = clr_in_bus;
        if (v.drop_valid) mem_s_valid = 1'b0;
        chk({nm, ".cyc"}, 32'(wb_cyc_o), 32'd1);
        chk({nm, ".adr"}, 32'(wb_adr_o), 32'(v.exp_adr));
        chk({nm, ".sel"}, 32'(wb_sel_o), 32'(v.exp_sel));
        chk({nm, ".we"},  32'(wb_we_o),  32'(v.exp_we));
        chk({nm, ".dat"}, wb_dat_o, v.wdata);
        stable_ok = 1'b1;
        done      = 1'b0;
        while (!done && lat < 2000) begin
            if (mem_s_ready) begin
                done = 1'b1;
            end else begin
                if (!wb_stb_o || !wb_cyc_o || wb_adr_o !== v.exp_adr ||
                    wb_sel_o !== v.exp_sel || wb_we_o !== v.exp_we ||
                    wb_dat_o !== v.wdata)
                    stable_ok = 1'b0;
                @(negedge clk);
                lat++;
                err_clr = 1'b0;
            end
        end
        err_clr = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, ".stable"}, 32'(stable_ok), 32'd1);
        chk({nm, ".rdata"}, mem_s_rdata, v.exp_rdata);
        chk({nm, ".stb_in_resp"}, 32'(wb_stb_o), 32'd0);
        chk({nm, ".bus_err"}, 32'(bus_err), 32'(v.exp_bus_err));
        @(negedge clk);
        mem_s_valid = 1'b0;
        chk({nm, ".ready_pulse"}, 32'(mem_s_ready), 32'd0);
        chk({nm, ".rdata_hold"}, mem_s_rdata, v.exp_rdata);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".ready"}, 32'(mem_s_ready), 32'd0);
        chk({nm, ".cyc"},   32'(wb_cyc_o),    32'd0);
        chk({nm, ".stb"},   32'(wb_stb_o),    32'd0);
        chk({nm, ".we"},    32'(wb_we_o),     32'd0);
        chk({nm, ".adr"},   32'(wb_adr_o),    32'd0);
        chk({nm, ".dat"},   wb_dat_o,         32'd0);
        chk({nm, ".sel"},   32'(wb_sel_o),    32'd0);
        chk({nm, ".rdata"}, mem_s_rdata,      32'd0);
        chk({nm, ".bus_err"}, 32'(bus_err),   32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        int   r0, s0;
        bit   seen_ready;

        //             addr          wdata         wstrb ws ack err drop clr rdata_in      exp_adr     sel   we exp_rdata     lat  berr
        vecs[0] = '{32'hC000_0010, 32'h0000_0000, 4'h0, 0, 1,  0,  0,   0, 32'h1234_5678, 24'h000004, 4'hF, 0, 32'h1234_5678, 2, 0};
        vecs[1] = '{32'hC000_0103, 32'hAABB_CCDD, 4'h8, 3, 1,  0,  0,   0, 32'h5555_5555, 24'h000040, 4'h8, 1, 32'h0000_0000, 5, 0};
        vecs[2] = '{32'hC000_0020, 32'h0000_0000, 4'h0, 1, 1,  1,  0,   0, 32'h0BAD_F00D, 24'h000008, 4'hF, 0, 32'hDEAD_BEEF, 3, 1};
        vecs[3] = '{32'hC000_0044, 32'h1122_3344, 4'h3, 0, 0,  1,  1,   0, 32'h0000_0000, 24'h000011, 4'h3, 1, 32'h0000_0000, 2, 1};
        vecs[4] = '{32'hC3FF_FFFC, 32'h0000_0000, 4'h0, 2, 1,  0,  0,   1, 32'hCAFE_F00D, 24'hFFFFFF, 4'hF, 0, 32'hCAFE_F00D, 4, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        // Table-driven vectors.
        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // err_clr coincident with a new err: set wins.
        v = vecs[2];
        v.ws = 0;
        v.exp_lat = 2;
        do_req(v, 1'b1, "err_vs_clr");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_alone", 32'(bus_err), 32'd0);

        // Back-to-back: valid reasserted in the cycle after each ready.
        r0 = ready_cnt;
        s0 = stb_rises;
        do_req(vecs[0], 1'b0, "b2b0");
        do_req(vecs[1], 1'b0, "b2b1");
        do_req(vecs[0], 1'b0, "b2b2");
        chk("b2b.wb_cycles", 32'(stb_rises - s0), 32'd3);
        chk("b2b.ready_pulses", 32'(ready_cnt - r0), 32'd3);

        // Reset while a Wishbone cycle is waiting for its ack.
        r0 = ready_cnt;
        mem_s_valid = 1'b1;
        mem_s_addr  = 32'hC000_0010;
        mem_s_wstrb = 4'h0;
        slv_ack_en  = 1'b0;
        slv_err_en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midbus.stb_before", 32'(wb_stb_o), 32'd1);
        resetn = 1'b0;
        #1;
        chk_all_zero("midbus_reset");
        @(negedge clk);
        mem_s_valid = 1'b0;
        slv_ack_en  = 1'b1;
        resetn      = 1'b1;
        @(negedge clk);
        chk("midbus.no_ready", 32'(ready_cnt - r0), 32'd0);
        do_req(vecs[0], 1'b0, "after_reset");

        // Slave that never answers.
        v = vecs[0];
        v.ack = 1'b0;
        v.err = 1'b0;
`ifdef PICOMEM_WB_TIMEOUT_EN
        // Watchdog of 8 cycles: ready 8 cycles after stb rises.
        v.exp_lat     = 9;
        v.exp_rdata   = 32'hDEAD_BEEF;
        v.exp_bus_err = 1'b1;
        do_req(v, 1'b0, "timeout");
`else
        mem_s_valid = 1'b1;
        mem_s_addr  = v.addr;
        mem_s_wstrb = 4'h0;
        slv_ack_en  = 1'b0;
        slv_err_en  = 1'b0;
        seen_ready  = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (mem_s_ready) seen_ready = 1'b1;
        end
        chk("no_timeout.ready", 32'(seen_ready), 32'd0);
        chk("no_timeout.stb_held", 32'(wb_stb_o), 32'd1);
        mem_s_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        slv_ack_en = 1'b1;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
